nibble_serial_alu_ctrl: RTL and testbench

- Sequencing stage wrapped around the 4-bit ALU datapath.
- Accepts a wide operand pair plus op code on a valid/ready command port, then drives the 4-bit ALU one nibble per cycle, LSB nibble first.
- Chains the ALU carry-out into the next nibble's carry-in.
- Collects the per-nibble sums and final CF/OF into a registered result presented on a valid/ready result port.

---
 rtl/nibble_serial_alu_ctrl.sv | 153 +++++++++++++++
 tb/tb_nibble_serial_alu_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_alu_ctrl.sv
// Sequences a W-bit add/logic op through an external 4-bit ALU, LSB nibble first, chaining carry.
// Latency NIBBLES+1 cycles from accept to res_valid; a held result blocks new commands until res_ready.
module nibble_serial_alu_ctrl #(
    parameter int NIBBLES = 4,
    localparam int W = 4 * NIBBLES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_op,
    input  logic [W-1:0] cmd_a,
    input  logic [W-1:0] cmd_b,
    input  logic         cmd_cin,
    output logic [3:0]   alu_a,
    output logic [3:0]   alu_b,
    output logic         alu_cin,
    output logic         alu_op1,
    output logic         alu_op0,
    input  logic [3:0]   alu_s,
    input  logic         alu_cf,
    input  logic         alu_of,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_s,
    output logic         res_cf,
    output logic         res_of
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [1:0]       op_q, op_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     res_s_q, res_s_d;
    logic             res_cf_q, res_cf_d;
    logic             res_of_q, res_of_d;
    logic             res_vld_q, res_vld_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            carry_q   <= 1'b0;
            op_q      <= 2'b00;
            a_q       <= '0;
            b_q       <= '0;
            res_s_q   <= '0;
            res_cf_q  <= 1'b0;
            res_of_q  <= 1'b0;
            res_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            carry_q   <= carry_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            res_s_q   <= res_s_d;
            res_cf_q  <= res_cf_d;
            res_of_q  <= res_of_d;
            res_vld_q <= res_vld_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (cmd_valid) state_d = S_RUN;
            S_RUN:   if (idx_q == IDX_LAST) state_d = S_DONE;
            S_DONE:  if (res_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ALU is driven only while RUN; everything is parked at zero otherwise.
    always_comb begin
        cmd_ready = (state_q == S_IDLE) && rst_n;
        alu_a     = 4'h0;
        alu_b     = 4'h0;
        alu_cin   = 1'b0;
        alu_op1   = 1'b0;
        alu_op0   = 1'b0;
        if (state_q == S_RUN) begin
            for (int i = 0; i < NIBBLES; i++) begin
                if (idx_q == i[IDX_W-1:0]) begin
                    alu_a = a_q[4*i +: 4];
                    alu_b = b_q[4*i +: 4];
                end
            end
            alu_op1 = op_q[1];
            alu_op0 = op_q[0];
            alu_cin = (op_q == 2'b00) ? carry_q : 1'b0;
        end
    end

    always_comb begin
        idx_d     = idx_q;
        carry_d   = carry_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        res_s_d   = res_s_q;
        res_cf_d  = res_cf_q;
        res_of_d  = res_of_q;
        res_vld_d = res_vld_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    a_d     = cmd_a;
                    b_d     = cmd_b;
                    op_d    = cmd_op;
                    carry_d = cmd_cin;
                    idx_d   = '0;
                end
            end
            S_RUN: begin
                for (int i = 0; i < NIBBLES; i++) begin
                    if (idx_q == i[IDX_W-1:0]) res_s_d[4*i +: 4] = alu_s;
                end
                carry_d = alu_cf;
                idx_d   = idx_q + IDX_ONE;
                // Only the top nibble's flags describe the full-width result.
                if (idx_q == IDX_LAST) begin
                    res_cf_d  = alu_cf;
                    res_of_d  = alu_of;
                    res_vld_d = 1'b1;
                end
            end
            S_DONE: begin
                if (res_ready) res_vld_d = 1'b0;
            end
            default: ;
        endcase
    end

    assign res_valid = res_vld_q;
    assign res_s     = res_s_q;
    assign res_cf    = res_cf_q;
    assign res_of    = res_of_q;

endmodule

// File: tb/tb_nibble_serial_alu_ctrl.sv
// Directed plus random bench for nibble_serial_alu_ctrl, with a behavioural 4-bit ALU attached.
module tb_nibble_serial_alu_ctrl;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [W-1:0] cmd_a;
    logic [W-1:0] cmd_b;
    logic         cmd_cin;
    logic [3:0]   alu_a;
    logic [3:0]   alu_b;
    logic         alu_cin;
    logic         alu_op1;
    logic         alu_op0;
    logic [3:0]   alu_s;
    logic         alu_cf;
    logic         alu_of;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_s;
    logic         res_cf;
    logic         res_of;

    int checks = 0;
    int errors = 0;

    nibble_serial_alu_ctrl #(.NIBBLES(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cin(cmd_cin),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
        .alu_op1(alu_op1), .alu_op0(alu_op0),
        .alu_s(alu_s), .alu_cf(alu_cf), .alu_of(alu_of),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_s(res_s), .res_cf(res_cf), .res_of(res_of)
    );

    always #5 clk = ~clk;

    // 4-bit ALU: 00 add, 01 zero, 10 AND, 11 XOR.
    always_comb begin
        logic [4:0] t;
        t      = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_cin};
        alu_s  = 4'h0;
        alu_cf = 1'b0;
        alu_of = 1'b0;
        case ({alu_op1, alu_op0})
            2'b00: begin
                alu_s  = t[3:0];
                alu_cf = t[4];
                alu_of = (alu_a[3] == alu_b[3]) && (t[3] != alu_a[3]);
            end
            2'b01:   alu_s = 4'h0;
            2'b10:   alu_s = alu_a & alu_b;
            default: alu_s = alu_a ^ alu_b;
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Whole-word result {of, cf, s} computed directly at width W.
    function automatic logic [W+1:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic cin);
        logic [W:0] sum;
        logic       of;
        case (op)
            2'b00: begin
                sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
                of  = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
                return {of, sum};
            end
            2'b01:   return '0;
            2'b10:   return {2'b00, a & b};
            default: return {2'b00, a ^ b};
        endcase
    endfunction

    // Carry into nibble i = carry out of the low 4*i bits of the full add.
    function automatic logic exp_cin(input logic [1:0] op, input logic [W-1:0] a,
                                     input logic [W-1:0] b, input logic cin, input int i);
        logic [63:0] m;
        logic [63:0] t;
        if (op != 2'b00) return 1'b0;
        if (i == 0) return cin;
        m = (64'd1 << (4 * i)) - 64'd1;
        t = (64'(a) & m) + (64'(b) & m) + 64'(cin);
        return t[4 * i];
    endfunction

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic send(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin);
        int n;
        n         = 0;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_cin   = cin;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready_before_accept", 64'(cmd_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic check_run(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic cin);
        logic [W-1:0] sa;
        logic [W-1:0] sb;
        logic [W+1:0] r;
        for (int i = 0; i < N; i++) begin
            sa = a >> (4 * i);
            sb = b >> (4 * i);
            chk("alu_a", 64'(alu_a), 64'(sa[3:0]));
            chk("alu_b", 64'(alu_b), 64'(sb[3:0]));
            chk("alu_op", 64'({alu_op1, alu_op0}), 64'(op));
            chk("alu_cin", 64'(alu_cin), 64'(exp_cin(op, a, b, cin, i)));
            chk("res_valid_in_run", 64'(res_valid), 64'd0);
            chk("cmd_ready_in_run", 64'(cmd_ready), 64'd0);
            @(negedge clk);
        end
        r = model(op, a, b, cin);
        chk("res_valid_latency", 64'(res_valid), 64'd1);
        chk("res_s", 64'(res_s), 64'(r[W-1:0]));
        chk("res_cf", 64'(res_cf), 64'(r[W]));
        chk("res_of", 64'(res_of), 64'(r[W+1]));
        chk("alu_a_idle_done", 64'(alu_a), 64'd0);
    endtask

    task automatic retire(input int delay);
        res_ready = 1'b0;
        for (int d = 0; d < delay; d++) begin
            @(negedge clk);
            chk("res_valid_held", 64'(res_valid), 64'd1);
            chk("cmd_ready_done", 64'(cmd_ready), 64'd0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("res_valid_retired", 64'(res_valid), 64'd0);
        chk("cmd_ready_after_retire", 64'(cmd_ready), 64'd1);
    endtask

    initial begin
        logic [1:0]   rop;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_a     = '0;
        cmd_b     = '0;
        cmd_cin   = 1'b0;
        res_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_res_s", 64'(res_s), 64'd0);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst_alu", 64'({alu_a, alu_b, alu_cin, alu_op1, alu_op0}), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
        @(negedge clk);

        // Carry ripple across nibbles
        send(2'b00, 16'h00FF, 16'h0001, 1'b0);
        check_run(2'b00, 16'h00FF, 16'h0001, 1'b0);
        chk("t1_res_s", 64'(res_s), 64'h0100);
        chk("t1_flags", 64'({res_cf, res_of}), 64'd0);
        retire(0);

        send(2'b00, 16'hFFFF, 16'h0001, 1'b0);
        check_run(2'b00, 16'hFFFF, 16'h0001, 1'b0);
        chk("t2a_res", 64'({res_cf, res_of, res_s}), 64'({2'b10, 16'h0000}));
        retire(1);

        send(2'b00, 16'h7FFF, 16'h0001, 1'b0);
        check_run(2'b00, 16'h7FFF, 16'h0001, 1'b0);
        chk("t2b_res", 64'({res_cf, res_of, res_s}), 64'({2'b01, 16'h8000}));
        retire(0);

        send(2'b00, 16'h1234, 16'h1111, 1'b1);
        chk("t3_cin0", 64'(alu_cin), 64'd1);
        check_run(2'b00, 16'h1234, 16'h1111, 1'b1);
        chk("t3_res", 64'({res_cf, res_s}), 64'({1'b0, 16'h2346}));
        retire(0);

        send(2'b01, 16'hABCD, 16'h1234, 1'b1);
        check_run(2'b01, 16'hABCD, 16'h1234, 1'b1);
        chk("t4_res", 64'({res_cf, res_s}), 64'd0);
        retire(0);

        // Backpressure with a pending command offered during DONE
        send(2'b00, 16'h00FF, 16'h0001, 1'b0);
        check_run(2'b00, 16'h00FF, 16'h0001, 1'b0);
        cmd_op = 2'b00; cmd_a = 16'h1234; cmd_b = 16'h1111; cmd_cin = 1'b1;
        cmd_valid = 1'b1;
        for (int d = 0; d < 3; d++) begin
            @(negedge clk);
            chk("t5_res_valid", 64'(res_valid), 64'd1);
            chk("t5_res_s", 64'(res_s), 64'h0100);
            chk("t5_cmd_ready", 64'(cmd_ready), 64'd0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("t5_idle_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("t5_idle_res_valid", 64'(res_valid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check_run(2'b00, 16'h1234, 16'h1111, 1'b1);
        retire(0);

        // Reset asserted across the second RUN edge
        send(2'b00, 16'h00FF, 16'h0001, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_res_valid", 64'(res_valid), 64'd0);
        chk("t6_res_s", 64'(res_s), 64'd0);
        chk("t6_alu", 64'({alu_a, alu_b, alu_cin, alu_op1, alu_op0}), 64'd0);
        chk("t6_cmd_ready_in_rst", 64'(cmd_ready), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("t6_cmd_ready_release", 64'(cmd_ready), 64'd1);
        send(2'b00, 16'h7FFF, 16'h0001, 1'b0);
        check_run(2'b00, 16'h7FFF, 16'h0001, 1'b0);
        retire(0);

        for (int k = 0; k < 40; k++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = W'($urandom);
            rb  = W'($urandom);
            rc  = 1'($urandom_range(0, 1));
            send(rop, ra, rb, rc);
            check_run(rop, ra, rb, rc);
            retire($urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
